// File: rtl/cmp_sweep_scheduler.sv
// cmp_sweep_scheduler: runs comparator measurement sweeps over the ref, S11 and S21
// channels. For each enabled channel it raises the swing enable and waits a settle
// time. It then pulses triger, counts comparator activity over a fixed window, and
// offers the count on a valid/ready result port.
// Optional build macro: CMP_SWEEP_EDGE_COUNT_EN. When defined, the window counts
// rising edges of the selected comparator instead of its high cycles.
module cmp_sweep_scheduler #(
   parameter int SETTLE_CYCLES = 64,
   parameter int WINDOW_CYCLES = 1024,
   parameter int CNT_W         = 16
) (
   input  logic             free_run_clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       ch_mask,
   input  logic             abort,
   input  logic             cmp_ref,
   input  logic             cmp_s11,
   input  logic             cmp_s21,
   output logic             ref_swing,
   output logic             S11_swing,
   output logic             S21_swing,
   output logic             triger,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [1:0]       res_ch,
   output logic [CNT_W-1:0] res_count,
   output logic             busy,
   output logic             done
);

   localparam int MAX_CYC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
   localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_MEASURE = 2'd2,
      S_REPORT  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         mask_q, mask_d;
   logic [1:0]         ch_q, ch_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [2:0]         swing_q, swing_d;
   logic               triger_q, triger_d;
   logic               res_valid_q, res_valid_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               cmp_sel;
   logic               hit;
   logic [2:0]         nxt;

   // Lowest set bit of a channel mask (caller guarantees at least one bit set when it matters).
   function automatic logic [1:0] lowest_ch(input logic [2:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else           return 2'd2;
   endfunction

   // Next enabled channel strictly above cur; MSB of the result flags that one exists.
   function automatic logic [2:0] next_ch(input logic [2:0] m, input logic [1:0] cur);
      logic [2:0] above;
      case (cur)
         2'd0:    above = m & 3'b110;
         2'd1:    above = m & 3'b100;
         default: above = 3'b000;
      endcase
      return {|above, lowest_ch(above)};
   endfunction

   function automatic logic [2:0] ch_onehot(input logic [1:0] c);
      case (c)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Saturating increment: the count sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
      if (inc && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
      else                             return c;
   endfunction

   // Select the comparator belonging to the channel currently being measured.
   always_comb begin
      case (ch_q)
         2'd0:    cmp_sel = cmp_ref;
         2'd1:    cmp_sel = cmp_s11;
         default: cmp_sel = cmp_s21;
      endcase
   end

`ifdef CMP_SWEEP_EDGE_COUNT_EN
   logic prev_q, prev_d;

   assign hit = cmp_sel & ~prev_q;

   // Track the previous comparator sample from the last settle cycle through the window,
   // so a comparator already high when the window opens is not counted as an edge.
   always_comb begin
      prev_d = prev_q;
      if ((state_q == S_SETTLE && tmr_q == '0) || state_q == S_MEASURE)
         prev_d = cmp_sel;
   end

   // Previous-sample register.
   always_ff @(posedge free_run_clk or posedge reset) begin
      if (reset) prev_q <= 1'b0;
      else       prev_q <= prev_d;
   end
`else
   assign hit = cmp_sel;
`endif

   // Next-state and registered-output logic; abort overrides everything outside IDLE.
   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      ch_d     = ch_q;
      tmr_d    = tmr_q;
      count_d  = count_q;
      triger_d = 1'b0;
      done_d   = 1'b0;
      nxt      = next_ch(mask_q, ch_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (|ch_mask) begin
                  mask_d  = ch_mask;
                  ch_d    = lowest_ch(ch_mask);
                  tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
                  state_d = S_SETTLE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_SETTLE: begin
            if (tmr_q == '0) begin
               state_d  = S_MEASURE;
               tmr_d    = TMR_W'(WINDOW_CYCLES - 1);
               count_d  = '0;
               triger_d = 1'b1;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_MEASURE: begin
            count_d = sat_inc(count_q, hit);
            if (tmr_q == '0) state_d = S_REPORT;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         S_REPORT: begin
            if (res_ready) begin
               if (nxt[2]) begin
                  ch_d    = nxt[1:0];
                  tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
                  state_d = S_SETTLE;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && state_q != S_IDLE) begin
         state_d  = S_IDLE;
         tmr_d    = '0;
         count_d  = '0;
         triger_d = 1'b0;
         done_d   = 1'b0;
      end

      busy_d      = (state_d != S_IDLE);
      res_valid_d = (state_d == S_REPORT);
      swing_d     = (state_d == S_SETTLE || state_d == S_MEASURE) ? ch_onehot(ch_d) : 3'b000;
   end

   // State, counters and registered outputs.
   always_ff @(posedge free_run_clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         ch_q        <= '0;
         tmr_q       <= '0;
         count_q     <= '0;
         swing_q     <= '0;
         triger_q    <= 1'b0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         ch_q        <= ch_d;
         tmr_q       <= tmr_d;
         count_q     <= count_d;
         swing_q     <= swing_d;
         triger_q    <= triger_d;
         res_valid_q <= res_valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign ref_swing = swing_q[0];
   assign S11_swing = swing_q[1];
   assign S21_swing = swing_q[2];
   assign triger    = triger_q;
   assign res_valid = res_valid_q;
   assign res_ch    = ch_q;
   assign res_count = count_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_cmp_sweep_scheduler.sv
// Testbench for cmp_sweep_scheduler. Two instances share all stimulus: one with an
// 8-bit result counter, one with a 3-bit counter to exercise saturation. Stimulus is
// prerecorded per cycle, played into the DUTs, and the recorded outputs are checked
// against a schedule computed from the sweep rules.
module tb_cmp_sweep_scheduler;

   localparam int SET  = 4;
   localparam int WIN  = 16;
   localparam int MAXN = 400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, abort, cmp_ref, cmp_s11, cmp_s21, res_ready;
   logic [2:0] ch_mask;

   logic       ref_sw_a, s11_sw_a, s21_sw_a, trig_a, valid_a, busy_a, done_a;
   logic [1:0] ch_a;
   logic [7:0] cnt_a;
   logic       ref_sw_b, s11_sw_b, s21_sw_b, trig_b, valid_b, busy_b, done_b;
   logic [1:0] ch_b;
   logic [2:0] cnt_b;

   cmp_sweep_scheduler #(.SETTLE_CYCLES(SET), .WINDOW_CYCLES(WIN), .CNT_W(8)) dut_a (
      .free_run_clk(clk), .reset(reset), .start(start), .ch_mask(ch_mask), .abort(abort),
      .cmp_ref(cmp_ref), .cmp_s11(cmp_s11), .cmp_s21(cmp_s21),
      .ref_swing(ref_sw_a), .S11_swing(s11_sw_a), .S21_swing(s21_sw_a), .triger(trig_a),
      .res_valid(valid_a), .res_ready(res_ready), .res_ch(ch_a), .res_count(cnt_a),
      .busy(busy_a), .done(done_a));

   cmp_sweep_scheduler #(.SETTLE_CYCLES(SET), .WINDOW_CYCLES(WIN), .CNT_W(3)) dut_b (
      .free_run_clk(clk), .reset(reset), .start(start), .ch_mask(ch_mask), .abort(abort),
      .cmp_ref(cmp_ref), .cmp_s11(cmp_s11), .cmp_s21(cmp_s21),
      .ref_swing(ref_sw_b), .S11_swing(s11_sw_b), .S21_swing(s21_sw_b), .triger(trig_b),
      .res_valid(valid_b), .res_ready(res_ready), .res_ch(ch_b), .res_count(cnt_b),
      .busy(busy_b), .done(done_b));

   // Per-cycle stimulus.
   logic [2:0] mask_tr [MAXN];
   logic [2:0] cmp_tr  [MAXN];
   logic       start_tr[MAXN];
   logic       abort_tr[MAXN];
   logic       ready_tr[MAXN];

   // Observed outputs. Vector bits: {busy, S21, S11, ref, triger, res_valid, done}.
   logic [6:0] ov_a  [MAXN];
   logic [6:0] ov_b  [MAXN];
   logic [1:0] och_a [MAXN];
   logic [1:0] och_b [MAXN];
   logic [7:0] ocnt_a[MAXN];
   logic [2:0] ocnt_b[MAXN];

   // Expected outputs.
   logic [6:0] ev  [MAXN];
   logic [1:0] ech [MAXN];
   int         ecnt[MAXN];

   int tests = 0;
   int fails = 0;

   task automatic clear_stim();
      for (int k = 0; k < MAXN; k++) begin
         mask_tr[k]  = 3'b000;
         cmp_tr[k]   = 3'b000;
         start_tr[k] = 1'b0;
         abort_tr[k] = 1'b0;
         ready_tr[k] = 1'b1;
      end
   endtask

   // Plays n cycles of stimulus; called just after a rising edge.
   task automatic play(input int n);
      for (int k = 0; k < n; k++) begin
         start     = start_tr[k];
         ch_mask   = mask_tr[k];
         abort     = abort_tr[k];
         res_ready = ready_tr[k];
         {cmp_s21, cmp_s11, cmp_ref} = cmp_tr[k];
         @(negedge clk);
         ov_a[k]   = {busy_a, s21_sw_a, s11_sw_a, ref_sw_a, trig_a, valid_a, done_a};
         ov_b[k]   = {busy_b, s21_sw_b, s11_sw_b, ref_sw_b, trig_b, valid_b, done_b};
         och_a[k]  = ch_a;
         och_b[k]  = ch_b;
         ocnt_a[k] = cnt_a;
         ocnt_b[k] = cnt_b;
         @(posedge clk);
         #1;
      end
      start = 1'b0; abort = 1'b0; res_ready = 1'b0; ch_mask = 3'b000;
      {cmp_s21, cmp_s11, cmp_ref} = 3'b000;
   endtask

   // Reference schedule: sweep started in cycle 0 with mask m. Each enabled channel,
   // ascending, gets SET settle cycles then WIN window cycles, then reports until the
   // first ready cycle; the next channel settles in the cycle after. An abort while
   // busy clears everything from the following cycle on.
   function automatic void build_expect(input logic [2:0] m, input int n);
      int t, w0, r, h, cnt, a;
      for (int k = 0; k < MAXN; k++) begin
         ev[k] = '0; ech[k] = '0; ecnt[k] = 0;
      end
      if (m == 3'b000) begin
         ev[1][0] = 1'b1;
      end else begin
         t = 1;
         for (int c = 0; c < 3; c++) begin
            if (m[c]) begin
               for (int k = t; k < t + SET + WIN && k < MAXN; k++) begin
                  ev[k][6] = 1'b1;
                  ev[k][3 + c] = 1'b1;
               end
               w0 = t + SET;
               if (w0 < MAXN) ev[w0][2] = 1'b1;
               cnt = 0;
               for (int k = w0; k < w0 + WIN && k < MAXN; k++) begin
`ifdef CMP_SWEEP_EDGE_COUNT_EN
                  if (cmp_tr[k][c] && !cmp_tr[k - 1][c]) cnt++;
`else
                  if (cmp_tr[k][c]) cnt++;
`endif
               end
               r = w0 + WIN;
               h = r;
               while (h < n && !ready_tr[h]) h++;
               for (int k = r; k <= h && k < MAXN; k++) begin
                  ev[k][6] = 1'b1;
                  ev[k][1] = 1'b1;
                  ech[k]   = 2'(c);
                  ecnt[k]  = cnt;
               end
               t = h + 1;
            end
         end
         if (t < MAXN) ev[t][0] = 1'b1;
      end
      a = -1;
      for (int k = 0; k < n; k++)
         if (a < 0 && abort_tr[k] && ev[k][6]) a = k;
      if (a >= 0)
         for (int k = a + 1; k < MAXN; k++) begin
            ev[k] = '0; ech[k] = '0; ecnt[k] = 0;
         end
   endfunction

   task automatic test_reset();
      logic [19:0] snap;
      reset = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0; ch_mask = 3'b000;
      {cmp_s21, cmp_s11, cmp_ref} = 3'b000;
      #1 reset = 1'b1;
      #2;
      snap = {busy_a, s21_sw_a, s11_sw_a, ref_sw_a, trig_a, valid_a, done_a, ch_a, cnt_a, 1'b0};
      tests++;
      if (snap !== 20'd0) begin
         fails++; $display("FAIL reset_outputs_a: got %h want 0", snap);
      end
      tests++;
      if ({busy_b, s21_sw_b, s11_sw_b, ref_sw_b, trig_b, valid_b, done_b, ch_b, cnt_b} !== 12'd0) begin
         fails++; $display("FAIL reset_outputs_b: got %b want 0",
                           {busy_b, s21_sw_b, s11_sw_b, ref_sw_b, trig_b, valid_b, done_b, ch_b, cnt_b});
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_channel();
      int n = 30;
      clear_stim();
      start_tr[0] = 1'b1; mask_tr[0] = 3'b010;
      for (int k = 0; k < n; k++) cmp_tr[k] = 3'b010;
      play(n);
      build_expect(3'b010, n);
      for (int k = 0; k < n; k++) begin
         tests++;
         if ({ov_a[k], ov_b[k]} !== {ev[k], ev[k]}) begin
            fails++; $display("FAIL single_trace cycle %0d: got %b/%b want %b", k, ov_a[k], ov_b[k], ev[k]);
         end
         if (ev[k][1]) begin
            tests++;
            if ({och_a[k], och_b[k], ocnt_a[k], ocnt_b[k]} !==
                {ech[k], ech[k], (ecnt[k] > 255) ? 8'd255 : 8'(ecnt[k]), (ecnt[k] > 7) ? 3'd7 : 3'(ecnt[k])}) begin
               fails++; $display("FAIL single_result cycle %0d: got ch %0d cnt %0d/%0d want ch %0d cnt %0d",
                                 k, och_a[k], ocnt_a[k], ocnt_b[k], ech[k], ecnt[k]);
            end
         end
      end
      tests++;
      if (!(ov_a[5][2] && !ov_a[4][2] && !ov_a[6][2])) begin
         fails++; $display("FAIL single_triger: got t4..6 %b%b%b want 010", ov_a[4][2], ov_a[5][2], ov_a[6][2]);
      end
      tests++;
      if ({ov_a[1][4], ov_a[20][4], ov_a[21][4]} !== 3'b110) begin
         fails++; $display("FAIL single_swing: got %b want 110", {ov_a[1][4], ov_a[20][4], ov_a[21][4]});
      end
      tests++;
`ifdef CMP_SWEEP_EDGE_COUNT_EN
      if ({ov_a[21][1], och_a[21], ocnt_a[21]} !== {1'b1, 2'd1, 8'd0}) begin
`else
      if ({ov_a[21][1], och_a[21], ocnt_a[21]} !== {1'b1, 2'd1, 8'd16}) begin
`endif
         fails++; $display("FAIL single_report: got valid %b ch %0d cnt %0d", ov_a[21][1], och_a[21], ocnt_a[21]);
      end
      tests++;
      if ({ov_a[21][0], ov_a[22][0], ov_a[22][6]} !== 3'b010) begin
         fails++; $display("FAIL single_done: got %b want 010", {ov_a[21][0], ov_a[22][0], ov_a[22][6]});
      end
   endtask

   task automatic test_two_channels();
      int n = 50;
      int dones = 0;
      int s11_hi = 0;
      int ph;
`ifdef CMP_SWEEP_EDGE_COUNT_EN
      ph = 1;
`else
      ph = 0;
`endif
      clear_stim();
      start_tr[0] = 1'b1; mask_tr[0] = 3'b101;
      for (int k = 0; k < n; k++) cmp_tr[k][0] = ((k + 1 + ph) % 2 == 0);
      play(n);
      build_expect(3'b101, n);
      for (int k = 0; k < n; k++) begin
         tests++;
         if ({ov_a[k], ov_b[k]} !== {ev[k], ev[k]}) begin
            fails++; $display("FAIL two_trace cycle %0d: got %b/%b want %b", k, ov_a[k], ov_b[k], ev[k]);
         end
         if (ev[k][1]) begin
            tests++;
            if ({och_a[k], och_b[k], ocnt_a[k], ocnt_b[k]} !==
                {ech[k], ech[k], (ecnt[k] > 255) ? 8'd255 : 8'(ecnt[k]), (ecnt[k] > 7) ? 3'd7 : 3'(ecnt[k])}) begin
               fails++; $display("FAIL two_result cycle %0d: got ch %0d cnt %0d/%0d want ch %0d cnt %0d",
                                 k, och_a[k], ocnt_a[k], ocnt_b[k], ech[k], ecnt[k]);
            end
         end
         if (ov_a[k][0]) dones++;
         if (ov_a[k][4]) s11_hi++;
      end
      tests++;
      if ({och_a[21], ocnt_a[21], och_a[42], ocnt_a[42]} !== {2'd0, 8'd8, 2'd2, 8'd0}) begin
         fails++; $display("FAIL two_results: got (%0d,%0d) (%0d,%0d) want (0,8) (2,0)",
                           och_a[21], ocnt_a[21], och_a[42], ocnt_a[42]);
      end
      tests++;
      if (dones != 1 || s11_hi != 0) begin
         fails++; $display("FAIL two_done_s11: got dones %0d s11 cycles %0d want 1 0", dones, s11_hi);
      end
   endtask

   task automatic test_backpressure();
      int n = 60;
      clear_stim();
      start_tr[0] = 1'b1; mask_tr[0] = 3'b011;
      for (int k = 0; k < n; k++) cmp_tr[k] = 3'($urandom);
      for (int k = 21; k <= 30; k++) ready_tr[k] = 1'b0;
      play(n);
      build_expect(3'b011, n);
      for (int k = 0; k < n; k++) begin
         tests++;
         if ({ov_a[k], ov_b[k]} !== {ev[k], ev[k]}) begin
            fails++; $display("FAIL bp_trace cycle %0d: got %b/%b want %b", k, ov_a[k], ov_b[k], ev[k]);
         end
         if (ev[k][1]) begin
            tests++;
            if ({och_a[k], och_b[k], ocnt_a[k], ocnt_b[k]} !==
                {ech[k], ech[k], (ecnt[k] > 255) ? 8'd255 : 8'(ecnt[k]), (ecnt[k] > 7) ? 3'd7 : 3'(ecnt[k])}) begin
               fails++; $display("FAIL bp_result cycle %0d: got ch %0d cnt %0d/%0d want ch %0d cnt %0d",
                                 k, och_a[k], ocnt_a[k], ocnt_b[k], ech[k], ecnt[k]);
            end
         end
      end
      tests++;
      if ({ov_a[31][5:3], ov_a[31][1], ov_a[32][4], ov_a[32][1]} !== 6'b000110) begin
         fails++; $display("FAIL bp_handoff: got %b want 000110",
                           {ov_a[31][5:3], ov_a[31][1], ov_a[32][4], ov_a[32][1]});
      end
   endtask

   task automatic test_idle_start_rules();
      int n = 5;
      int s11_hi = 0;
      clear_stim();
      start_tr[0] = 1'b1; mask_tr[0] = 3'b000;
      play(n);
      build_expect(3'b000, n);
      for (int k = 0; k < n; k++) begin
         tests++;
         if ({ov_a[k], ov_b[k]} !== {ev[k], ev[k]}) begin
            fails++; $display("FAIL zero_mask_trace cycle %0d: got %b/%b want %b", k, ov_a[k], ov_b[k], ev[k]);
         end
      end
      tests++;
      if ({ov_a[1][0], ov_a[1][6], ov_a[2][0]} !== 3'b100) begin
         fails++; $display("FAIL zero_mask_done: got %b want 100", {ov_a[1][0], ov_a[1][6], ov_a[2][0]});
      end
      n = 30;
      clear_stim();
      start_tr[0] = 1'b1; mask_tr[0] = 3'b001;
      start_tr[10] = 1'b1; mask_tr[10] = 3'b110;
      for (int k = 0; k < n; k++) cmp_tr[k] = 3'($urandom);
      play(n);
      build_expect(3'b001, n);
      for (int k = 0; k < n; k++) begin
         tests++;
         if ({ov_a[k], ov_b[k]} !== {ev[k], ev[k]}) begin
            fails++; $display("FAIL busy_start_trace cycle %0d: got %b/%b want %b", k, ov_a[k], ov_b[k], ev[k]);
         end
         if (ev[k][1]) begin
            tests++;
            if ({och_a[k], och_b[k], ocnt_a[k], ocnt_b[k]} !==
                {ech[k], ech[k], (ecnt[k] > 255) ? 8'd255 : 8'(ecnt[k]), (ecnt[k] > 7) ? 3'd7 : 3'(ecnt[k])}) begin
               fails++; $display("FAIL busy_start_result cycle %0d: got ch %0d cnt %0d want ch %0d cnt %0d",
                                 k, och_a[k], ocnt_a[k], ech[k], ecnt[k]);
            end
         end
         if (ov_a[k][4] || ov_a[k][5]) s11_hi++;
      end
      tests++;
      if (s11_hi != 0 || ov_a[22][0] !== 1'b1) begin
         fails++; $display("FAIL busy_start_ignored: got other-swing cycles %0d done22 %b want 0 1", s11_hi, ov_a[22][0]);
      end
   endtask

   task automatic test_reset_mid_measure();
      int n = 10;
      clear_stim();
      start_tr[0] = 1'b1; mask_tr[0] = 3'b001;
      for (int k = 0; k < n; k++) cmp_tr[k] = 3'b111;
      play(n);
      build_expect(3'b001, n);
      for (int k = 0; k < n; k++) begin
         tests++;
         if ({ov_a[k], ov_b[k]} !== {ev[k], ev[k]}) begin
            fails++; $display("FAIL rst_mid_trace cycle %0d: got %b/%b want %b", k, ov_a[k], ov_b[k], ev[k]);
         end
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({busy_a, s21_sw_a, s11_sw_a, ref_sw_a, trig_a, valid_a, done_a, ch_a, cnt_a,
           busy_b, ref_sw_b, cnt_b} !== 22'd0) begin
         fails++; $display("FAIL rst_mid_outputs: got busy %b ref %b cnt %0d/%0d want all 0",
                           busy_a, ref_sw_a, cnt_a, cnt_b);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_abort();
      int n = 30;
      int dones = 0;
      clear_stim();
      start_tr[0] = 1'b1; mask_tr[0] = 3'b011;
      abort_tr[3] = 1'b1;
      for (int k = 0; k < n; k++) cmp_tr[k] = 3'($urandom);
      play(n);
      build_expect(3'b011, n);
      for (int k = 0; k < n; k++) begin
         tests++;
         if ({ov_a[k], ov_b[k]} !== {ev[k], ev[k]}) begin
            fails++; $display("FAIL abort_trace cycle %0d: got %b/%b want %b", k, ov_a[k], ov_b[k], ev[k]);
         end
         if (ov_a[k][0]) dones++;
      end
      tests++;
      if (ov_a[3][6] !== 1'b1 || ov_a[4] !== 7'd0 || dones != 0) begin
         fails++; $display("FAIL abort_idle: got c3 busy %b c4 %b dones %0d want 1 0000000 0", ov_a[3][6], ov_a[4], dones);
      end
      clear_stim();
      start_tr[0] = 1'b1; mask_tr[0] = 3'b100;
      for (int k = 0; k < n; k++) cmp_tr[k] = 3'($urandom);
      play(n);
      build_expect(3'b100, n);
      for (int k = 0; k < n; k++) begin
         tests++;
         if ({ov_a[k], ov_b[k]} !== {ev[k], ev[k]}) begin
            fails++; $display("FAIL after_abort_trace cycle %0d: got %b/%b want %b", k, ov_a[k], ov_b[k], ev[k]);
         end
         if (ev[k][1]) begin
            tests++;
            if ({och_a[k], ocnt_a[k]} !== {ech[k], (ecnt[k] > 255) ? 8'd255 : 8'(ecnt[k])}) begin
               fails++; $display("FAIL after_abort_result cycle %0d: got ch %0d cnt %0d want ch %0d cnt %0d",
                                 k, och_a[k], ocnt_a[k], ech[k], ecnt[k]);
            end
         end
      end
      tests++;
      if (ov_a[22][0] !== 1'b1) begin
         fails++; $display("FAIL after_abort_done: got %b want 1", ov_a[22][0]);
      end
   endtask

   task automatic test_saturation();
      int n = 30;
      clear_stim();
      start_tr[0] = 1'b1; mask_tr[0] = 3'b001;
`ifdef CMP_SWEEP_EDGE_COUNT_EN
      for (int k = 0; k < n; k++) cmp_tr[k] = {2'b00, k[0]};
`else
      for (int k = 0; k < n; k++) cmp_tr[k] = 3'b001;
`endif
      play(n);
      tests++;
`ifdef CMP_SWEEP_EDGE_COUNT_EN
      if ({ocnt_a[21], ocnt_b[21]} !== {8'd8, 3'd7}) begin
`else
      if ({ocnt_a[21], ocnt_b[21]} !== {8'd16, 3'd7}) begin
`endif
         fails++; $display("FAIL saturation: got %0d/%0d want full/7", ocnt_a[21], ocnt_b[21]);
      end
      tests++;
      if ({ov_b[21][1], och_b[21]} !== {1'b1, 2'd0}) begin
         fails++; $display("FAIL saturation_report: got valid %b ch %0d want 1 0", ov_b[21][1], och_b[21]);
      end
   endtask

   task automatic test_random();
      int n = 300;
      logic [2:0] m;
      for (int it = 0; it < 8; it++) begin
         clear_stim();
         m = 3'($urandom_range(1, 7));
         start_tr[0] = 1'b1; mask_tr[0] = m;
         for (int k = 0; k < n; k++) begin
            cmp_tr[k] = 3'($urandom);
            ready_tr[k] = (k >= 150) ? 1'b1 : 1'($urandom);
         end
         if (it == 0) abort_tr[0] = 1'b1;
         if (it == 5) abort_tr[$urandom_range(1, 60)] = 1'b1;
         play(n);
         build_expect(m, n);
         for (int k = 0; k < n; k++) begin
            tests++;
            if ({ov_a[k], ov_b[k]} !== {ev[k], ev[k]}) begin
               fails++; $display("FAIL random_trace it %0d mask %b cycle %0d: got %b/%b want %b",
                                 it, m, k, ov_a[k], ov_b[k], ev[k]);
            end
            if (ev[k][1]) begin
               tests++;
               if ({och_a[k], och_b[k], ocnt_a[k], ocnt_b[k]} !==
                   {ech[k], ech[k], (ecnt[k] > 255) ? 8'd255 : 8'(ecnt[k]), (ecnt[k] > 7) ? 3'd7 : 3'(ecnt[k])}) begin
                  fails++; $display("FAIL random_result it %0d cycle %0d: got ch %0d cnt %0d/%0d want ch %0d cnt %0d",
                                    it, k, och_a[k], ocnt_a[k], ocnt_b[k], ech[k], ecnt[k]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_two_channels();
      test_backpressure();
      test_idle_start_rules();
      test_reset_mid_measure();
      test_abort();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
